// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state encoding and constants for the data-memory responder
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port 32-bit word RAM, no reset
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // write-first is irrelevant here: reads of a word never coincide with its own write
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store responder that stalls the pipeline for LATENCY cycles
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int IDX_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, ram_rdata;
  logic [IDX_W-1:0] ram_idx;
  logic req, mis, we, unused_addr;
  assign unused_addr = ^addr_i[31:IDX_W+2];
  assign req = MemRead_i | MemWrite_i;
  assign mis = |(addr_q[1:0] & WORD_ALIGN_MASK);
  assign stall_o = req & (state_q != DONE);
  assign misalign_o = (state_q == DONE) & mis;
  assign we = rst_n_i & (state_q == DONE) & wr_q & ~mis;
  // in IDLE the RAM is addressed straight from the pipeline so a LATENCY=1 load has data in DONE
  assign ram_idx = (state_q == IDLE) ? addr_i[IDX_W+1:2] : addr_q[IDX_W+1:2];
  assign rdata_o = ((state_q == DONE) & ~wr_q) ? (mis ? '0 : ram_rdata) : rdata_q;
  assign rdata_d = rdata_o;
  // next-state, countdown and request capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && req) begin
      state_d = (LATENCY == 1) ? DONE : WAIT;
      cnt_d = CNT_W'(LATENCY - 1);
      wr_d = MemWrite_i;
      addr_d = addr_i[IDX_W+1:0];
      wdata_d = wdata_i;
    end else if (state_q == WAIT) begin
      state_d = !req ? IDLE : (cnt_q == CNT_W'(1)) ? DONE : WAIT;
      cnt_d = req ? cnt_q - 1'b1 : cnt_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // FSM, counter and held load data, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  // request latches need no reset: they are only consumed after being loaded
  always_ff @(posedge clk_i) begin
    wr_q <= wr_d;
    addr_q <= addr_d;
    wdata_q <= wdata_d;
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk_i(clk_i),
    .we(we),
    .idx(ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
endmodule
